sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Single-clock, parametrised FIFO; one instance replaces hand-cascaded fixed-size FIFO pairs.
//  Any power-of-2 depth and any data width, with exact occupancy count.
//  Adds programmable almost-full/almost-empty flags and sticky overflow/underflow error flags.
//  Sits between producer/consumer stages in the Module-2 datapath; all signals are in the clk domain.
// PARAMETERS
//  DATA_W     8      data word width in bits
//  DEPTH      4096   number of entries; must be a power of 2 and >= 4
//  AF_THRESH  4092   almost_full asserted when count >= AF_THRESH
//  AE_THRESH  4      almost_empty asserted when count <= AE_THRESH
//  Derived: ADDR_W = $clog2(DEPTH); CNT_W = ADDR_W+1
// PORTS
//  clk           in   1       clock; all logic on posedge
//  rst           in   1       reset: asynchronous, active-high
//  wr_en         in   1       write request
//  wr_data       in   DATA_W  write data
//  rd_en         in   1       read request
//  rd_data       out  DATA_W  read data
//  rd_valid      out  1       rd_data holds a valid word
//  full          out  1       count == DEPTH
//  empty         out  1       count == 0
//  almost_full   out  1       count >= AF_THRESH
//  almost_empty  out  1       count <= AE_THRESH
//  count         out  CNT_W   current occupancy, 0..DEPTH
//  overflow      out  1       sticky: a write was rejected
//  underflow     out  1       sticky: a read was rejected
//  clr_err       in   1       synchronous clear of overflow/underflow
// BEHAVIOUR
//  - Reset (async, active-high), all outputs:
//    - count=0, empty=1, full=0, almost_empty=1, almost_full=0.
//    - overflow=0, underflow=0, rd_data=0, rd_valid=0.
//    - Both pointers go to 0. Storage RAM is not reset.
//  - Accepting requests:
//    - Write accepted iff wr_en && !full. Read accepted iff rd_en && !empty.
//    - The decision uses the registered flags, before the clock edge.
//  - Simultaneous wr_en && rd_en:
//    - Both are accepted when 0 < count < DEPTH; count is unchanged.
//    - When full: the read is accepted and the write is rejected (overflow=1); count becomes DEPTH-1.
//    - When empty: the write is accepted and the read is rejected (underflow=1); count becomes 1.
//  - Flags: full, empty, almost_* and count are registered. They update on the same edge as the accepted operation.
//  - Pointers are ADDR_W bits wide and wrap from DEPTH-1 to 0 with no special handling.
//  - Occupancy comes only from the count register. Pointer equality is never used to decide full/empty.
//  - overflow/underflow: set on a rejected request and held until clr_err or rst.
//  - clr_err has priority over a same-cycle set; it clears on that edge.
//  - Standard read mode: rd_data is registered with 1-cycle latency.
//    - Read accepted at edge N: rd_data = head word and rd_valid=1 after edge N.
//    - rd_valid=0 after any edge with no accepted read; rd_data holds its last value.
//  - rst asserted mid-operation: all state is lost immediately and the FIFO is empty after release.
//    - The first accepted write after release is read first.
// CONFIGURATION
//  - Macro: FIFO_FWFT_EN (first-word-fall-through).
//  - Defined:
//    - rd_valid = !empty. rd_data presents the head word combinationally from storage whenever !empty.
//    - An accepted read pops the head; the next word appears after that edge.
//    - rd_data is don't-care while empty.
//    - Reset: rd_valid=0.
//  - Undefined: standard 1-cycle registered read as above.
//  - Flags, count and error behaviour are identical in both modes.
// TESTING  (DATA_W=8, DEPTH=16, AF_THRESH=14, AE_THRESH=2)
//  1. Reset, then idle -> empty=1, almost_empty=1, full=0, almost_full=0, count=0, overflow=0, underflow=0, rd_valid=0.
//  2. Write 0x00..0x0F on 16 consecutive cycles:
//     -> almost_empty=0 after the 3rd write; almost_full=1 after the 14th; full=1 and count=16 after the 16th.
//  3. While full, wr_en with 0xAA -> count stays 16, overflow=1.
//     -> clr_err pulse -> overflow=0; the stored data is unchanged.
//  4. Read 16 words -> rd_data = 0x00..0x0F in order (1-cycle latency; FWFT: zero latency); empty=1 after the last read.
//     -> a 17th rd_en -> underflow=1, rd_valid=0.
//  5. Wrap and simultaneous access:
//     -> write 10, read 10, write 0x50..0x59, read -> 0x50..0x59 in order across the pointer wrap.
//     -> wr_en&&rd_en at count=5 -> count stays 5.
//     -> wr_en&&rd_en when full -> count=15, overflow=1.
//  6. Fill to count=7, assert rst between edges -> all outputs take reset values immediately (asynchronously).
//     -> after release, write 0x33 then read -> 0x33, count=0.

Source files
------------

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock parametrised FIFO with occupancy count and error flags
//
// Purpose:
//   Single-clock FIFO for any power-of-2 depth (>= 4) and any data width.
//   It keeps an exact occupancy count and drives programmable almost-full and
//   almost-empty flags. The overflow and underflow error flags are sticky.
//   Occupancy is taken only from the count register. The pointers are never
//   compared to decide full or empty.
//
// Configuration:
//   FIFO_FWFT_EN  defined   : first-word-fall-through. rd_data shows the head
//                             word from storage and rd_valid = !empty.
//                 undefined : registered read with 1-cycle latency.
//
// Ports:
//   clk           in   1       clock, posedge
//   rst           in   1       asynchronous active-high reset
//   wr_en         in   1       write request
//   wr_data       in   DATA_W  write data
//   rd_en         in   1       read request
//   rd_data       out  DATA_W  read data
//   rd_valid      out  1       rd_data holds a valid word
//   full          out  1       count == DEPTH
//   empty         out  1       count == 0
//   almost_full   out  1       count >= AF_THRESH
//   almost_empty  out  1       count <= AE_THRESH
//   count         out  CNT_W   occupancy 0..DEPTH
//   overflow      out  1       sticky: a write was rejected
//   underflow     out  1       sticky: a read was rejected
//   clr_err       in   1       synchronous clear of overflow/underflow
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4096,
  parameter int AF_THRESH = 4092,
  parameter int AE_THRESH = 4,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int CNT_W    = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, empty_q, afull_q, aempty_q;
  logic              ovf_q, unf_q;
  logic              wr_acc, rd_acc;

  // The accept decision uses the registered flags. This gives the required
  // priority when full (read wins) and when empty (write wins).
  assign wr_acc = wr_en && !full_q;
  assign rd_acc = rd_en && !empty_q;

  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // The flags are registered from the next count, so they change on the same
  // edge as the operation that moved the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= AF_C);
      aempty_q <= (count_d <= AE_C);
    end
  end

  // clr_err takes priority over a set in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (clr_err) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_en && full_q)  ovf_q <= 1'b1;
      if (rd_en && empty_q) unf_q <= 1'b1;
    end
  end

  // Storage has no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

`ifdef FIFO_FWFT_EN
  // The head word falls through from storage. Its value is meaningless while empty.
  assign rd_data  = mem[rd_ptr_q];
  assign rd_valid = !empty_q;
`else
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  // rd_data keeps its last value when no read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= mem[rd_ptr_q];
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param with a queue reference model
module tb_sync_fifo_param;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF_T   = 14;
  localparam int AE_T   = 2;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_en = 1'b0;
  logic              clr_err = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, full, empty, almost_full, almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow, underflow;

  sync_fifo_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_T), .AE_THRESH(AE_T)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] m_rdata = '0;
  bit                m_rvalid = 1'b0;
  bit                m_ovf = 1'b0;
  bit                m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"},        32'(count),        32'(n));
    chk({tag, ".empty"},        32'(empty),        32'(n == 0));
    chk({tag, ".full"},         32'(full),         32'(n == DEPTH));
    chk({tag, ".almost_full"},  32'(almost_full),  32'(n >= AF_T));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE_T));
    chk({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
    chk({tag, ".underflow"},    32'(underflow),    32'(m_unf));
`ifdef FIFO_FWFT_EN
    chk({tag, ".rd_valid"},     32'(rd_valid),     32'(n != 0));
    if (n != 0) chk({tag, ".rd_data"}, 32'(rd_data), 32'(mq[0]));
`else
    chk({tag, ".rd_valid"},     32'(rd_valid),     32'(m_rvalid));
    chk({tag, ".rd_data"},      32'(rd_data),      32'(m_rdata));
`endif
  endtask

  // Applies one cycle of stimulus, updates the model by the FIFO rules, then checks.
  task automatic step(input string tag, input bit w, input logic [DATA_W-1:0] d,
                      input bit r, input bit c);
    bit was_full, was_empty, wacc, racc;
    @(negedge clk);
    wr_en = w; wr_data = d; rd_en = r; clr_err = c;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    wacc = w && !was_full;
    racc = r && !was_empty;
    if (racc) m_rdata = mq.pop_front();
    if (wacc) mq.push_back(d);
    m_rvalid = racc;
    if (c) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_unf = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("reset");
    step("idle", 0, 8'h00, 0, 0);

    for (int i = 0; i < 16; i++) begin
      step("fill", 1, 8'(i), 0, 0);
      if (i == 2)  chk("fill.ae_drop", 32'(almost_empty), 32'd0);
      if (i == 13) chk("fill.af_rise", 32'(almost_full),  32'd1);
    end
    chk("fill.full16", 32'(full), 32'd1);

    step("ovf_write", 1, 8'hAA, 0, 0);
    chk("ovf_write.sticky", 32'(overflow), 32'd1);
    step("ovf_hold", 0, 8'h00, 0, 0);
    step("clr_err", 0, 8'h00, 0, 1);

    for (int i = 0; i < 16; i++) step("drain", 0, 8'h00, 1, 0);
`ifndef FIFO_FWFT_EN
    chk("drain.last_word", 32'(rd_data), 32'h0F);
`endif
    step("underflow", 0, 8'h00, 1, 0);
    chk("underflow.rd_valid", 32'(rd_valid), 32'd0);
    step("clr_unf", 0, 8'h00, 0, 1);

    for (int i = 0; i < 10; i++) step("adv_w", 1, 8'($urandom), 0, 0);
    for (int i = 0; i < 10; i++) step("adv_r", 0, 8'h00, 1, 0);
    for (int i = 0; i < 10; i++) step("wrap_w", 1, 8'(8'h50 + i), 0, 0);
    for (int i = 0; i < 10; i++) step("wrap_r", 0, 8'h00, 1, 0);

    for (int i = 0; i < 5; i++) step("mid_w", 1, 8'(8'h60 + i), 0, 0);
    step("simul_mid", 1, 8'h6F, 1, 0);
    chk("simul_mid.count5", 32'(count), 32'd5);
    for (int i = 0; i < 11; i++) step("top_w", 1, 8'(8'h70 + i), 0, 0);
    step("simul_full", 1, 8'hEE, 1, 0);
    chk("simul_full.count15", 32'(count), 32'd15);
    chk("simul_full.ovf", 32'(overflow), 32'd1);
    step("clr2", 0, 8'h00, 0, 1);
    for (int i = 0; i < 15; i++) step("empty_out", 0, 8'h00, 1, 0);
    step("simul_empty", 1, 8'h5A, 1, 0);
    chk("simul_empty.count1", 32'(count), 32'd1);
    step("clr3", 0, 8'h00, 1, 1);

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 99) < 55), 8'($urandom),
           ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 5));
    end

    step("pre_rst_clr", 0, 8'h00, 0, 1);
    while (mq.size() != 0) step("pre_rst_drain", 0, 8'h00, 1, 0);
    for (int i = 0; i < 7; i++) step("pre_rst_w", 1, 8'(8'h20 + i), 0, 0);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst_w", 1, 8'h33, 0, 0);
    step("post_rst_r", 0, 8'h00, 1, 0);
`ifndef FIFO_FWFT_EN
    chk("post_rst.data33", 32'(rd_data), 32'h33);
`endif
    chk("post_rst.count0", 32'(count), 32'd0);
    step("idle_end", 0, 8'h00, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
